// File: rtl/demux_dispatch_if.sv
// Upstream word handshake, per-channel readiness and dispatch outputs of demux_dispatch.
// master drives words and channel readiness; slave is the dispatch block itself.
interface demux_dispatch_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_dest;
    logic [DATA_W-1:0] in_data;
    logic              mode;
    logic [3:0]        ch_ready;
    logic              strobe;
    logic [1:0]        sel;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        rr_ptr;
    logic [15:0]       stall_cnt;

    // Valid/ready: a word transfers on a rising edge where in_valid and in_ready are both high;
    // in_ready depends only on registered occupancy, never on in_valid.
    modport master (
        output in_valid, in_dest, in_data, mode, ch_ready,
        input  in_ready, strobe, sel, data_out, rr_ptr, stall_cnt
    );

    modport slave (
        input  in_valid, in_dest, in_data, mode, ch_ready,
        output in_ready, strobe, sel, data_out, rr_ptr, stall_cnt
    );
endinterface

// File: rtl/demux_dispatch.sv
// Dispatch stage for a 1-to-4 demux: 2-entry word FIFO, addressed or round-robin channel choice,
// registered one-cycle strobe with select and broadcast data.
module demux_dispatch #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    demux_dispatch_if.slave   bus
);
    localparam int EW = DATA_W + 2;

    logic [EW-1:0]     mem_q [2];
    logic [EW-1:0]     mem_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              strobe_q, strobe_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [15:0]       stall_q, stall_d;

    logic [EW-1:0]     head;
    logic [1:0]        head_dest;
    logic [DATA_W-1:0] head_data;
    logic              push;
    logic              fire;
    logic [1:0]        target;
    logic [1:0]        cand;
    logic              wr_idx;

    assign head      = mem_q[rd_ptr_q];
    assign head_dest = head[EW-1:DATA_W];
    assign head_data = head[DATA_W-1:0];
    assign push      = bus.in_valid && bus.in_ready;
    // Tail slot sits one past the head only when exactly one word is buffered.
    assign wr_idx    = rd_ptr_q ^ count_q[0];

    // Channel choice for the head word; round-robin takes the first ready channel from rr_ptr on.
    always_comb begin
        fire   = 1'b0;
        target = head_dest;
        cand   = rr_ptr_q;
        if (count_q != 2'd0) begin
            if (!bus.mode) begin
                fire = bus.ch_ready[head_dest];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    cand = rr_ptr_q + 2'(i);
                    if (!fire && bus.ch_ready[cand]) begin
                        fire   = 1'b1;
                        target = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        strobe_d = fire;
        sel_d    = sel_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        stall_d  = stall_q;

        if (push) begin
            mem_d[wr_idx] = {bus.in_dest, bus.in_data};
        end
        if (fire) begin
            rd_ptr_d = ~rd_ptr_q;
            sel_d    = target;
            data_d   = head_data;
            if (bus.mode) begin
                rr_ptr_d = target + 2'd1;
            end
        end else if (count_q != 2'd0 && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end

        case ({push, fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            strobe_q <= 1'b0;
            sel_q    <= 2'd0;
            data_q   <= '0;
            rr_ptr_q <= 2'd0;
            stall_q  <= 16'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            strobe_q <= strobe_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            rr_ptr_q <= rr_ptr_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.strobe    = strobe_q;
    assign bus.sel       = sel_q;
    assign bus.data_out  = data_q;
    assign bus.rr_ptr    = rr_ptr_q;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_demux_dispatch.sv
// Randomized bench for demux_dispatch: queue-based reference model feeds an expected-dispatch
// scoreboard that a negedge monitor drains whenever the DUT strobes.
module tb_demux_dispatch;
  logic clk;
  logic rst_n;

  demux_dispatch_if #(.DATA_W(8)) bus ();

  demux_dispatch #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int chk_total = 0;
  int chk_pass  = 0;

  // Reference model state: buffered {dest,data} words, round-robin pointer, stall counter.
  logic [9:0] m_fifo[$];
  logic [9:0] exp_q[$];
  int         m_rr    = 0;
  int         m_stall = 0;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_total++;
    if (act === exp) chk_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_fifo.delete();
        exp_q.delete();
        m_rr    = 0;
        m_stall = 0;
      end else begin
        bit         fire;
        bit         do_push;
        int         tgt;
        logic [9:0] head;
        fire    = 0;
        tgt     = 0;
        head    = '0;
        do_push = bus.in_valid && (m_fifo.size() < 2);
        if (m_fifo.size() > 0) begin
          head = m_fifo[0];
          if (!bus.mode) begin
            tgt  = int'(head[9:8]);
            fire = bus.ch_ready[tgt];
          end else begin
            for (int k = 0; k < 4; k++) begin
              int c;
              c = (m_rr + k) % 4;
              if (!fire && bus.ch_ready[c]) begin
                fire = 1;
                tgt  = c;
              end
            end
          end
          if (fire) begin
            void'(m_fifo.pop_front());
            exp_q.push_back({2'(tgt), head[7:0]});
            if (bus.mode) m_rr = (tgt + 1) % 4;
          end else if (m_stall < 65535) begin
            m_stall++;
          end
        end
        if (do_push) m_fifo.push_back({bus.in_dest, bus.in_data});
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_strobe",   32'(bus.strobe),    32'd0);
        check("rst_sel",      32'(bus.sel),       32'd0);
        check("rst_data_out", 32'(bus.data_out),  32'd0);
        check("rst_rr_ptr",   32'(bus.rr_ptr),    32'd0);
        check("rst_stall",    32'(bus.stall_cnt), 32'd0);
      end else begin
        check("strobe", 32'(bus.strobe), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if (bus.strobe) check("sel_data", {22'd0, bus.sel, bus.data_out}, {22'd0, e});
        end
        check("in_ready",  32'(bus.in_ready),  32'(m_fifo.size() < 2));
        check("rr_ptr",    32'(bus.rr_ptr),    32'(m_rr));
        check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic push_word(input logic [1:0] d, input logic [7:0] v);
    int n;
    bus.in_valid = 1'b1;
    bus.in_dest  = d;
    bus.in_data  = v;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk_total++;
      $display("FAIL push_timeout actual=in_ready_low expected=accept within 200 cycles");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_dest  = 2'd0;
    bus.in_data  = 8'd0;
    bus.mode     = 1'b0;
    bus.ch_ready = 4'hF;

    // Reset held with random inputs.
    repeat (3) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_dest  = 2'($urandom_range(0, 3));
      bus.in_data  = 8'($urandom_range(0, 255));
      bus.mode     = 1'($urandom_range(0, 1));
      bus.ch_ready = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mode     = 1'b0;
    bus.ch_ready = 4'hF;
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Addressed streaming.
    push_word(2'd2, 8'hA5);
    push_word(2'd0, 8'h3C);
    push_word(2'd3, 8'hFF);
    repeat (3) @(negedge clk);

    // Backpressure until full, then release channel 1.
    bus.ch_ready = 4'h0;
    push_word(2'd1, 8'h11);
    push_word(2'd1, 8'h22);
    repeat (5) @(negedge clk);
    bus.ch_ready = 4'b0010;
    repeat (4) @(negedge clk);

    // Round-robin skipping unready channels and wrapping.
    bus.mode     = 1'b1;
    bus.ch_ready = 4'b1010;
    for (int i = 0; i < 4; i++) push_word(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    repeat (4) @(negedge clk);

    // Steady push with pop each cycle.
    bus.mode     = 1'b0;
    bus.ch_ready = 4'hF;
    for (int i = 0; i < 20; i++) push_word(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    repeat (3) @(negedge clk);

    // Reset with two words buffered.
    bus.ch_ready = 4'h0;
    push_word(2'd0, 8'h5A);
    push_word(2'd2, 8'hC3);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    bus.ch_ready = 4'hF;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Fully random traffic with occasional mode switches.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_dest  = 2'($urandom_range(0, 3));
      bus.in_data  = 8'($urandom_range(0, 255));
      bus.ch_ready = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.ch_ready = 4'hF;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end
endmodule

// File: doc/demux_dispatch.md
# demux_dispatch

Upstream dispatch stage for the 1-to-4 demultiplexer. It accepts destination-tagged words over a valid/ready handshake and buffers them in a 2-entry FIFO. It then issues each word as a single-cycle strobe together with a registered 2-bit select and a broadcast data bus. The strobe and select drive the demux's `data_in` and `sel`; the demux outputs become per-channel write enables for four consumers. Per-channel backpressure and a round-robin mode let the same block serve addressed and load-balanced traffic.

## Interface
- `DATA_W`, 8, width of the payload word broadcast to all four channels
- `clk`  input  1  single system clock, rising-edge
- `rst_n`  input  1  asynchronous, active-low reset
- `in_valid`  input  1  upstream word valid
- `in_ready`  output  1  block can accept a word this cycle
- `in_dest`  input  2  destination channel, 0..3; ignored in round-robin mode
- `in_data`  input  DATA_W  payload
- `mode`  input  1  0 = addressed, 1 = round-robin
- `ch_ready`  input  4  per-channel consumer ready; bit i = channel i
- `strobe`  output  1  one-cycle dispatch pulse, feeds demux `data_in`
- `sel`  output  2  channel select, feeds demux `sel`
- `data_out`  output  DATA_W  payload of the current dispatch
- `rr_ptr`  output  2  next channel to be tried in round-robin mode
- `stall_cnt`  output  16  cycles with a pending head word not dispatched; saturates at 16'hFFFF

## Operation
- FIFO, 2 entries of {dest, data}, with a 2-bit occupancy count of 0..2.
  - Push when `in_valid && in_ready`.
  - `in_ready` = (count != 2), combinational from the registered count.
  - Pop when a dispatch occurs.
  - Push and pop in the same cycle leave the count unchanged; the new word goes behind the head.
  - Push into an empty FIFO is allowed.
  - No push is possible when full, and no pop is possible when empty.
- Dispatch decision is made each cycle when count > 0:
  - **Addressed (`mode`=0):** target = head dest. Dispatch iff `ch_ready[target]`; otherwise hold.
  - **Round-robin (`mode`=1):** target = first channel with `ch_ready` high, searching `rr_ptr`, `rr_ptr`+1, `rr_ptr`+2, `rr_ptr`+3 (mod 4). If no channel is ready, hold. After a dispatch, `rr_ptr` = target+1 mod 4 (3 wraps to 0). In addressed mode `rr_ptr` does not change.
- On dispatch, the registered outputs load `strobe`=1, `sel`=target and `data_out`=head data.
- Without a dispatch, `strobe`=0 and `sel`/`data_out` hold their last values.
- `mode` is sampled every cycle. Switching mode does not flush the FIFO; the head word simply follows the new rule.
- `stall_cnt`:
  - Increments by 1 in each cycle where count > 0 and no dispatch occurs.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Error-free by construction: `in_dest` is always in range.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets:
  - FIFO empty, so `in_ready`=1 while `rst_n` is high.
  - `strobe`=0, `sel`=0, `data_out`=0, `rr_ptr`=0, `stall_cnt`=0.
- Asserting reset mid-operation discards buffered words immediately, with no partial strobe.
- Latency:
  - A word pushed at edge k can dispatch at edge k+1 at the earliest.
  - `strobe` is then high from edge k+1 to edge k+2.
  - `sel`/`data_out` are valid in the same cycle as `strobe`.
- Throughput: one dispatch per cycle sustained when the consumer stays ready. The FIFO never fills under that condition.
- `ch_ready` is sampled combinationally for the decision at each edge. A consumer dropping ready in cycle c prevents a dispatch at the edge ending cycle c.
- Consecutive dispatches produce back-to-back strobe cycles, with `sel` changing between them as required.
- The demux output equals `strobe` routed by `sel`, so exactly one channel enable pulses per dispatch.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs → `strobe`=0, `sel`=0, `data_out`=0, `rr_ptr`=0, `stall_cnt`=0. After release, `in_ready`=1.
- **Addressed streaming:**
  - Stimulus: `mode`=0, `ch_ready`=4'hF; push (2,8'hA5), (0,8'h3C), (3,8'hFF) on consecutive cycles.
  - Response: strobes on 3 consecutive cycles, each one edge after its push, with `sel` = 2, 0, 3 and `data_out` = A5, 3C, FF.
- **Backpressure and full:**
  - Stimulus: `mode`=0, `ch_ready`=4'h0; push (1,8'h11), (1,8'h22).
  - Response: `in_ready`=0 after the second push and `stall_cnt` increments each cycle.
  - Stimulus: raise `ch_ready`[1].
  - Response: strobes `sel`=1, data 11 then 22; `in_ready` returns to 1 after the first pop.
- **Round-robin skip and wrap:**
  - Stimulus: `mode`=1, `ch_ready`=4'b1010, `rr_ptr`=0; push 4 words.
  - Response: `sel` sequence 1, 3, 1, 3, with `rr_ptr` sequence 2, 0, 2, 0.
- **Simultaneous push/pop at count 1:** with steady pushes and pops → count stays 1, `in_ready` stays 1, and order is preserved.
- **Reset mid-operation:**
  - Stimulus: assert `rst_n`=0 with 2 words buffered, then release.
  - Response: no strobe occurs, `stall_cnt`=0, and `in_ready`=1.
